// File: rtl/fir2d_pkg.sv
// rtl/fir2d_pkg.sv - shared constants, types and sum-to-channel conversion; FIR2D_SATURATE_EN selects clamping
package fir2d_pkg;
    localparam int DW   = 8;
    localparam int RGB  = 24;
    localparam int TAPS = 9;
    localparam int AW   = 20;
    localparam int CW   = $clog2(TAPS);

    typedef logic [RGB-1:0]       pixel_t;
    typedef logic [DW-1:0]        chan_t;
    typedef logic signed [DW-1:0] coef_t;
    typedef logic signed [AW-1:0] acc_t;
    typedef logic [CW-1:0]        cnt_t;

    function automatic chan_t to_chan(input acc_t sum);
`ifdef FIR2D_SATURATE_EN
        if (sum < acc_t'(0))
            return '0;
        else if (sum > acc_t'(2**DW - 1))
            return '1;
        else
            return chan_t'(sum);
`else
        return chan_t'(sum);
`endif
    endfunction
endpackage

// File: rtl/fir2d_lane.sv
// rtl/fir2d_lane.sv - one filter lane: three per-channel MACs and the result register
module fir2d_lane
    import fir2d_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   sample_en,
    input  logic   clear,
    input  logic   done,
    input  pixel_t coef_sel,
    input  pixel_t pixel,
    output pixel_t result
);

    for (genvar c = 0; c < 3; c++) begin : g_ch
        chan_t                px;
        coef_t                cf;
        logic signed [2*DW:0] prod;
        acc_t                 prod_ext;
        acc_t                 acc;
        chan_t                res;

        assign px       = pixel[c*DW +: DW];
        assign cf       = coef_sel[c*DW +: DW];
        // Zero-extend the pixel so it multiplies as unsigned against the signed tap.
        assign prod     = $signed({1'b0, px}) * cf;
        assign prod_ext = acc_t'(prod);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
                res <= '0;
            end else begin
                if (done)
                    res <= to_chan(acc);
                if (clear)
                    acc <= '0;
                else if (done)
                    acc <= sample_en ? prod_ext : '0;
                else if (sample_en)
                    acc <= acc + prod_ext;
            end
        end
    end

    assign result = {g_ch[2].res, g_ch[1].res, g_ch[0].res};

endmodule

// File: rtl/fir2d_quad_lane.sv
// rtl/fir2d_quad_lane.sv - 4-lane 3x3 RGB FIR core: coefficient bank, counters, result strobe; FIR2D_SATURATE_EN selects clamping
module fir2d_quad_lane
    import fir2d_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [RGB-1:0] input_data1,
    input  logic [RGB-1:0] input_data2,
    input  logic [RGB-1:0] input_data3,
    input  logic [RGB-1:0] input_data4,
    input  logic           valid_dmac,
    input  logic           tc_set,
    output logic [RGB-1:0] output_data1,
    output logic [RGB-1:0] output_data2,
    output logic [RGB-1:0] output_data3,
    output logic [RGB-1:0] output_data4,
    output logic           valid_core
);

    pixel_t coef [TAPS];
    cnt_t   tap_cnt;
    cnt_t   pix_cnt;
    logic   fin;
    logic   load;
    logic   sample;
    logic   last_pix;
    pixel_t lane_in  [4];
    pixel_t lane_out [4];

    assign load     = valid_dmac & tc_set;
    assign sample   = valid_dmac & ~tc_set;
    assign last_pix = (pix_cnt == cnt_t'(TAPS-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++)
                coef[i] <= '0;
            tap_cnt    <= '0;
            pix_cnt    <= '0;
            fin        <= 1'b0;
            valid_core <= 1'b0;
        end else begin
            // fin marks the cycle in which the lanes register the completed window.
            fin        <= sample & last_pix;
            valid_core <= fin;
            if (load) begin
                coef[tap_cnt] <= input_data1;
                tap_cnt       <= (tap_cnt == cnt_t'(TAPS-1)) ? '0 : tap_cnt + cnt_t'(1);
                pix_cnt       <= '0;
            end else if (sample) begin
                pix_cnt <= last_pix ? '0 : pix_cnt + cnt_t'(1);
            end
        end
    end

    assign lane_in[0] = input_data1;
    assign lane_in[1] = input_data2;
    assign lane_in[2] = input_data3;
    assign lane_in[3] = input_data4;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        fir2d_lane u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .sample_en (sample),
            .clear     (load),
            .done      (fin),
            .coef_sel  (coef[pix_cnt]),
            .pixel     (lane_in[l]),
            .result    (lane_out[l])
        );
    end

    assign output_data1 = lane_out[0];
    assign output_data2 = lane_out[1];
    assign output_data3 = lane_out[2];
    assign output_data4 = lane_out[3];

endmodule

// File: tb/tb_fir2d_quad_lane.sv
// tb/tb_fir2d_quad_lane.sv - randomized self-checking bench for fir2d_quad_lane against a window-sum model
`timescale 1ns/1ps
module tb_fir2d_quad_lane;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] i1, i2, i3, i4;
    logic [23:0] o1, o2, o3, o4;
    logic        valid_dmac = 1'b0;
    logic        tc_set = 1'b0;
    logic        valid_core;

    int passed = 0;
    int total  = 0;

    logic [23:0] tap_m [9];
    int          tap_idx = 0;
    logic [23:0] win [4][9];
    logic [95:0] res_q [$];

    always #5 clk = ~clk;

    fir2d_quad_lane dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_data1  (i1),
        .input_data2  (i2),
        .input_data3  (i3),
        .input_data4  (i4),
        .valid_dmac   (valid_dmac),
        .tc_set       (tc_set),
        .output_data1 (o1),
        .output_data2 (o2),
        .output_data3 (o3),
        .output_data4 (o4),
        .valid_core   (valid_core)
    );

    always @(negedge clk)
        if (valid_core === 1'b1)
            res_q.push_back({o4, o3, o2, o1});

    function automatic logic [23:0] outl(input int l);
        case (l)
            0:       return o1;
            1:       return o2;
            2:       return o3;
            default: return o4;
        endcase
    endfunction

    // Per-channel dot product of window and taps, then the 8-bit conversion rule.
    function automatic logic [23:0] model(input int l);
        logic [23:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            int s;
            s = 0;
            for (int k = 0; k < 9; k++) begin
                logic signed [7:0] cb;
                cb = tap_m[k][c*8 +: 8];
                s += int'(win[l][k][c*8 +: 8]) * int'(cb);
            end
`ifdef FIR2D_SATURATE_EN
            if (s < 0) s = 0;
            else if (s > 255) s = 255;
`endif
            r[c*8 +: 8] = s[7:0];
        end
        return r;
    endfunction

    task automatic sample(input logic tc, input logic [23:0] a, b, c, d);
        @(negedge clk);
        valid_dmac = 1'b1; tc_set = tc;
        i1 = a; i2 = b; i3 = c; i4 = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_dmac = 1'b0; tc_set = 1'($urandom);
            i1 = 24'($urandom); i2 = 24'($urandom); i3 = 24'($urandom); i4 = 24'($urandom);
        end
    endtask

    task automatic load_taps(input logic [23:0] t [9]);
        for (int k = 0; k < 9; k++) begin
            sample(1'b1, t[k], 24'($urandom), 24'($urandom), 24'($urandom));
            tap_m[tap_idx] = t[k];
            tap_idx = (tap_idx + 1) % 9;
        end
    endtask

    task automatic load_random_taps();
        logic [23:0] t [9];
        for (int k = 0; k < 9; k++) t[k] = 24'($urandom);
        load_taps(t);
    endtask

    task automatic randomize_win();
        for (int l = 0; l < 4; l++)
            for (int k = 0; k < 9; k++)
                win[l][k] = 24'($urandom);
    endtask

    task automatic send_window(input int gap_at, input int gap_len);
        for (int k = 0; k < 9; k++) begin
            sample(1'b0, win[0][k], win[1][k], win[2][k], win[3][k]);
            if (k == gap_at) idle(gap_len);
        end
    endtask

    task automatic wait_result(output int lat);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            valid_dmac = 1'b0; tc_set = 1'b0;
            if (valid_core === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int l = 0; l < 4; l++) begin
            total++;
            if (outl(l) !== 24'h0) $display("FAIL reset_out lane%0d got %h exp 000000", l, outl(l));
            else passed++;
        end
        total++;
        if (valid_core !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid_core);
        else passed++;
        for (int k = 0; k < 9; k++) tap_m[k] = '0;
        tap_idx = 0;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_zero_sum();
        int lat;
        load_taps('{24'h020202, 24'h010101, 24'h000000, 24'h010101, 24'h000000,
                    24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFEFEFE});
        for (int l = 0; l < 4; l++) for (int k = 0; k < 9; k++) win[l][k] = 24'h101010;
        res_q.delete();
        send_window(-1, 0);
        wait_result(lat);
        total++;
        if (lat !== 2) $display("FAIL zero_sum_latency got %0d exp 2", lat);
        else passed++;
        for (int l = 0; l < 4; l++) begin
            total++;
            if (outl(l) !== model(l)) $display("FAIL zero_sum lane%0d got %h exp %h", l, outl(l), model(l));
            else passed++;
        end
        idle(3);
        total++;
        if (res_q.size() !== 1) $display("FAIL zero_sum_pulses got %0d exp 1", res_q.size());
        else passed++;
    endtask

    task automatic test_boundary();
        int lat;
        for (int l = 0; l < 4; l++) for (int k = 0; k < 9; k++) win[l][k] = '0;
        win[0][0] = 24'h646464;
        win[1][0] = 24'hFFFFFF;
        win[2][8] = 24'h101010;
        win[3][4] = 24'($urandom);
        win[3][0] = 24'($urandom);
        send_window(-1, 0);
        wait_result(lat);
        total++;
        if (lat !== 2) $display("FAIL boundary_latency got %0d exp 2", lat);
        else passed++;
        for (int l = 0; l < 4; l++) begin
            total++;
            if (outl(l) !== model(l)) $display("FAIL boundary lane%0d got %h exp %h", l, outl(l), model(l));
            else passed++;
        end
    endtask

    task automatic test_identity_gaps();
        int lat;
        logic [23:0] e [4];
        logic [23:0] centres [4];
        centres = '{24'h123456, 24'hABCDEF, 24'h00FF80, 24'h7F7F7F};
        load_taps('{24'h0, 24'h0, 24'h0, 24'h0, 24'h010101, 24'h0, 24'h0, 24'h0, 24'h0});
        for (int w = 0; w < 3; w++) begin
            randomize_win();
            if (w == 0) for (int l = 0; l < 4; l++) win[l][4] = centres[l];
            send_window(-1, 0);
            wait_result(lat);
            for (int l = 0; l < 4; l++) begin
                e[l] = model(l);
                total++;
                if (outl(l) !== e[l] || lat !== 2)
                    $display("FAIL identity w%0d lane%0d got %h exp %h lat %0d", w, l, outl(l), e[l], lat);
                else passed++;
            end
            idle(4);
            for (int l = 0; l < 4; l++) begin
                total++;
                if (outl(l) !== e[l]) $display("FAIL identity_hold w%0d lane%0d got %h exp %h", w, l, outl(l), e[l]);
                else passed++;
            end
        end
    endtask

    task automatic test_gap_mid();
        int lat;
        load_random_taps();
        randomize_win();
        res_q.delete();
        send_window(4, 3);
        wait_result(lat);
        for (int l = 0; l < 4; l++) begin
            total++;
            if (outl(l) !== model(l) || lat !== 2)
                $display("FAIL gap_mid lane%0d got %h exp %h lat %0d", l, outl(l), model(l), lat);
            else passed++;
        end
        idle(3);
        total++;
        if (res_q.size() !== 1) $display("FAIL gap_mid_pulses got %0d exp 1", res_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        int lat;
        load_taps('{24'h0, 24'h0, 24'h0, 24'h0, 24'h010101, 24'h0, 24'h0, 24'h0, 24'h0});
        randomize_win();
        for (int l = 0; l < 4; l++) win[l][4] = 24'h808080 | 24'($urandom);
        send_window(-1, 0);
        wait_result(lat);
        for (int k = 0; k < 5; k++) sample(1'b0, win[0][k], win[1][k], win[2][k], win[3][k]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int l = 0; l < 4; l++) begin
            total++;
            if (outl(l) !== 24'h0) $display("FAIL reset_mid_out lane%0d got %h exp 000000", l, outl(l));
            else passed++;
        end
        total++;
        if (valid_core !== 1'b0) $display("FAIL reset_mid_valid got %b exp 0", valid_core);
        else passed++;
        for (int k = 0; k < 9; k++) tap_m[k] = '0;
        tap_idx = 0;
        valid_dmac = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        randomize_win();
        send_window(-1, 0);
        wait_result(lat);
        for (int l = 0; l < 4; l++) begin
            total++;
            if (outl(l) !== 24'h0 || lat !== 2)
                $display("FAIL no_reload lane%0d got %h exp 000000 lat %0d", l, outl(l), lat);
            else passed++;
        end
        load_random_taps();
        randomize_win();
        send_window(-1, 0);
        wait_result(lat);
        for (int l = 0; l < 4; l++) begin
            total++;
            if (outl(l) !== model(l)) $display("FAIL after_reload lane%0d got %h exp %h", l, outl(l), model(l));
            else passed++;
        end
    endtask

    task automatic test_reload();
        int lat;
        load_taps('{24'h030303, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFDFDFD});
        for (int p = 0; p < 2; p++) begin
            for (int l = 0; l < 4; l++)
                for (int k = 0; k < 9; k++)
                    win[l][k] = (p == 0 || k == 0) ? 24'h0A0A0A : 24'h0;
            send_window(-1, 0);
            wait_result(lat);
            for (int l = 0; l < 4; l++) begin
                total++;
                if (outl(l) !== model(l) || lat !== 2)
                    $display("FAIL reload p%0d lane%0d got %h exp %h lat %0d", p, l, outl(l), model(l), lat);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [95:0] exp_q [$];
        logic [95:0] r;
        load_random_taps();
        res_q.delete();
        for (int w = 0; w < 3; w++) begin
            randomize_win();
            exp_q.push_back({model(3), model(2), model(1), model(0)});
            for (int k = 0; k < 9; k++) sample(1'b0, win[0][k], win[1][k], win[2][k], win[3][k]);
        end
        idle(4);
        total++;
        if (res_q.size() !== 3) $display("FAIL b2b_pulses got %0d exp 3", res_q.size());
        else passed++;
        for (int w = 0; w < 3; w++) begin
            r = (res_q.size() > 0) ? res_q.pop_front() : 96'hX;
            for (int l = 0; l < 4; l++) begin
                total++;
                if (r[l*24 +: 24] !== exp_q[w][l*24 +: 24])
                    $display("FAIL b2b w%0d lane%0d got %h exp %h", w, l, r[l*24 +: 24], exp_q[w][l*24 +: 24]);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        int lat;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 2) == 0) load_random_taps();
            randomize_win();
            send_window($urandom_range(0, 9) - 1, $urandom_range(0, 3));
            wait_result(lat);
            for (int l = 0; l < 4; l++) begin
                total++;
                if (outl(l) !== model(l) || lat !== 2)
                    $display("FAIL random it%0d lane%0d got %h exp %h lat %0d", it, l, outl(l), model(l), lat);
                else passed++;
            end
            idle($urandom_range(0, 2));
        end
    endtask

    initial begin
        i1 = '0; i2 = '0; i3 = '0; i4 = '0;
        test_reset();
        test_zero_sum();
        test_boundary();
        test_identity_gaps();
        test_gap_mid();
        test_reset_mid();
        test_reload();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d/%0d checks", passed, total);
        $fatal(1);
    end

endmodule
